// File: rtl/exec_issue_stage.sv
// Issue stage: latches one operation, holds operands steady for a fixed-latency external ALU,
// then captures and holds the result until downstream accepts it.
module exec_issue_stage #(
   parameter int unsigned WIDTH      = 32,
   parameter int unsigned MUL_CYCLES = 4,
   parameter int unsigned DIV_CYCLES = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [3:0]       in_sel,
   input  logic [4:0]       in_rd,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [3:0]       alu_sel,
   input  logic [WIDTH-1:0] alu_res,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_res,
   output logic [4:0]       out_rd,
   output logic             out_zero,
   output logic             out_neg,
   output logic             out_divz,
   output logic             busy
);

   localparam logic [3:0] SelMul  = 4'd2;
   localparam logic [3:0] SelDiv  = 4'd3;
   localparam logic [3:0] MulLoad = 4'(MUL_CYCLES - 1);
   localparam logic [3:0] DivLoad = 4'(DIV_CYCLES - 1);

   if (MUL_CYCLES < 1 || MUL_CYCLES > 15) begin : g_bad_mul
      $error("MUL_CYCLES out of range 1..15");
   end
   if (DIV_CYCLES < 1 || DIV_CYCLES > 15) begin : g_bad_div
      $error("DIV_CYCLES out of range 1..15");
   end

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StExec = 2'd1,
      StHold = 2'd2
   } state_e;

   state_e           r_state;
   state_e           w_state_next;
   logic [3:0]       r_cnt;
   logic [WIDTH-1:0] r_alu_a;
   logic [WIDTH-1:0] r_alu_b;
   logic [3:0]       r_alu_sel;
   logic [4:0]       r_rd_pend;
   logic [WIDTH-1:0] r_out_res;
   logic [4:0]       r_out_rd;
   logic             r_out_zero;
   logic             r_out_neg;
   logic             r_out_divz;

   logic             w_accept;
   logic             w_capture;
   logic [3:0]       w_lat_m1;

   always_comb begin
      in_ready = 1'b0;
      unique case (r_state)
         StIdle:  in_ready = 1'b1;
         StExec:  in_ready = 1'b0;
         StHold:  in_ready = out_ready;
         default: in_ready = 1'b0;
      endcase
   end

   always_comb begin
      w_accept  = in_valid && in_ready;
      w_capture = (r_state == StExec) && (r_cnt == 4'd0);
      w_lat_m1  = 4'd0;
      if (in_sel == SelMul) begin
         w_lat_m1 = MulLoad;
      end else if (in_sel == SelDiv) begin
         w_lat_m1 = DivLoad;
      end
   end

   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         StIdle: begin
            if (w_accept) w_state_next = StExec;
         end
         StExec: begin
            if (r_cnt == 4'd0) w_state_next = StHold;
         end
         StHold: begin
            // A release may coincide with the next accept; go straight back to EXEC.
            if (out_ready) w_state_next = w_accept ? StExec : StIdle;
         end
         default: w_state_next = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt     <= 4'd0;
         r_alu_a   <= '0;
         r_alu_b   <= '0;
         r_alu_sel <= 4'd0;
         r_rd_pend <= 5'd0;
      end else if (w_accept) begin
         r_cnt     <= w_lat_m1;
         r_alu_a   <= in_a;
         r_alu_b   <= in_b;
         r_alu_sel <= in_sel;
         r_rd_pend <= in_rd;
      end else if ((r_state == StExec) && (r_cnt != 4'd0)) begin
         r_cnt <= r_cnt - 4'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_out_res  <= '0;
         r_out_rd   <= 5'd0;
         r_out_zero <= 1'b0;
         r_out_neg  <= 1'b0;
         r_out_divz <= 1'b0;
      end else if (w_capture) begin
         r_out_res  <= alu_res;
         r_out_rd   <= r_rd_pend;
         r_out_zero <= (alu_res == '0);
         r_out_neg  <= alu_res[WIDTH-1];
         r_out_divz <= (r_alu_sel == SelDiv) && (r_alu_b == '0);
      end
   end

   assign alu_a     = r_alu_a;
   assign alu_b     = r_alu_b;
   assign alu_sel   = r_alu_sel;
   assign out_valid = (r_state == StHold);
   assign out_res   = r_out_res;
   assign out_rd    = r_out_rd;
   assign out_zero  = r_out_zero;
   assign out_neg   = r_out_neg;
   assign out_divz  = r_out_divz;
   assign busy      = (r_state != StIdle);

endmodule

// File: tb/tb_exec_issue_stage.sv
// Directed bench for exec_issue_stage: an opcode table through a reference ALU, plus
// hand sequences for EXEC-time input, backpressure handoff and mid-operation reset.
module tb_exec_issue_stage;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_a;
   logic [W-1:0] in_b;
   logic [3:0]   in_sel;
   logic [4:0]   in_rd;
   logic [W-1:0] alu_a;
   logic [W-1:0] alu_b;
   logic [3:0]   alu_sel;
   logic [W-1:0] alu_res;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_res;
   logic [4:0]   out_rd;
   logic         out_zero;
   logic         out_neg;
   logic         out_divz;
   logic         busy;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   exec_issue_stage #(
      .WIDTH      (W),
      .MUL_CYCLES (4),
      .DIV_CYCLES (8)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_sel    (in_sel),
      .in_rd     (in_rd),
      .alu_a     (alu_a),
      .alu_b     (alu_b),
      .alu_sel   (alu_sel),
      .alu_res   (alu_res),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_res   (out_res),
      .out_rd    (out_rd),
      .out_zero  (out_zero),
      .out_neg   (out_neg),
      .out_divz  (out_divz),
      .busy      (busy)
   );

   // Environment ALU; divide by zero yields all ones.
   always_comb begin
      alu_res = '0;
      case (alu_sel)
         4'd0:  alu_res = alu_a + alu_b;
         4'd1:  alu_res = alu_a - alu_b;
         4'd2:  alu_res = alu_a * alu_b;
         4'd3:  alu_res = (alu_b == '0) ? '1 : alu_a / alu_b;
         4'd4:  alu_res = alu_a & alu_b;
         4'd5:  alu_res = alu_a | alu_b;
         4'd6:  alu_res = alu_a ^ alu_b;
         4'd7:  alu_res = ~alu_a;
         4'd8:  alu_res = alu_a;
         4'd9:  alu_res = alu_b;
         4'd10: alu_res = alu_a << alu_b[4:0];
         4'd11: alu_res = alu_a >> alu_b[4:0];
         4'd12: alu_res = $unsigned($signed(alu_a) >>> alu_b[4:0]);
         4'd13: alu_res = alu_a + 32'd1;
         4'd14: alu_res = alu_a - 32'd1;
         default: alu_res = alu_a ^ alu_b;
      endcase
   end

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [3:0]  sel;
      logic [4:0]  rd;
      logic [31:0] res;
      logic        z;
      logic        n;
      logic        dz;
      int          lat;
   } vec_t;

   localparam int NV = 19;
   vec_t vecs [NV];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_op(input vec_t v, input int idx);
      int  cyc;
      bit  ir_bad;
      in_a      = v.a;
      in_b      = v.b;
      in_sel    = v.sel;
      in_rd     = v.rd;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      check($sformatf("v%0d in_ready_idle", idx), 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0;
      cyc      = 0;
      ir_bad   = 1'b0;
      while (!out_valid && cyc < 40) begin
         if (in_ready) ir_bad = 1'b1;
         tick();
         cyc++;
      end
      check($sformatf("v%0d latency", idx), 32'(cyc), 32'(v.lat));
      check($sformatf("v%0d in_ready_exec", idx), 32'(ir_bad), 32'd0);
      check($sformatf("v%0d res", idx), out_res, v.res);
      check($sformatf("v%0d rd", idx), 32'(out_rd), 32'(v.rd));
      check($sformatf("v%0d zero", idx), 32'(out_zero), 32'(v.z));
      check($sformatf("v%0d neg", idx), 32'(out_neg), 32'(v.n));
      check($sformatf("v%0d divz", idx), 32'(out_divz), 32'(v.dz));
      tick();
      check($sformatf("v%0d released", idx), {30'd0, out_valid, busy}, 32'd0);
   endtask

   initial begin
      vec_t vt;
      bit   bad;
      vecs[0]  = '{32'd5,        32'd7,        4'd0,  5'd1,  32'd12,       1'b0, 1'b0, 1'b0, 1};
      vecs[1]  = '{32'd3,        32'd5,        4'd1,  5'd2,  32'hFFFFFFFE, 1'b0, 1'b1, 1'b0, 1};
      vecs[2]  = '{32'd6,        32'd7,        4'd2,  5'd3,  32'd42,       1'b0, 1'b0, 1'b0, 4};
      vecs[3]  = '{32'd100,      32'd7,        4'd3,  5'd4,  32'd14,       1'b0, 1'b0, 1'b0, 8};
      vecs[4]  = '{32'd9,        32'd0,        4'd3,  5'd5,  32'hFFFFFFFF, 1'b0, 1'b1, 1'b1, 8};
      vecs[5]  = '{32'h0000FF00, 32'h0F0F0F0F, 4'd4,  5'd6,  32'h00000F00, 1'b0, 1'b0, 1'b0, 1};
      vecs[6]  = '{32'h000000F0, 32'h00000F00, 4'd5,  5'd7,  32'h00000FF0, 1'b0, 1'b0, 1'b0, 1};
      vecs[7]  = '{32'hFFFF0000, 32'h0000FFFF, 4'd6,  5'd8,  32'hFFFFFFFF, 1'b0, 1'b1, 1'b0, 1};
      vecs[8]  = '{32'h00000000, 32'h00000055, 4'd7,  5'd9,  32'hFFFFFFFF, 1'b0, 1'b1, 1'b0, 1};
      vecs[9]  = '{32'h80000000, 32'h00000001, 4'd8,  5'd10, 32'h80000000, 1'b0, 1'b1, 1'b0, 1};
      vecs[10] = '{32'h00000001, 32'h00001234, 4'd9,  5'd11, 32'h00001234, 1'b0, 1'b0, 1'b0, 1};
      vecs[11] = '{32'h00000001, 32'd31,       4'd10, 5'd12, 32'h80000000, 1'b0, 1'b1, 1'b0, 1};
      vecs[12] = '{32'h80000000, 32'd4,        4'd11, 5'd13, 32'h08000000, 1'b0, 1'b0, 1'b0, 1};
      vecs[13] = '{32'h80000000, 32'd4,        4'd12, 5'd14, 32'hF8000000, 1'b0, 1'b1, 1'b0, 1};
      vecs[14] = '{32'hFFFFFFFF, 32'd0,        4'd13, 5'd15, 32'h00000000, 1'b1, 1'b0, 1'b0, 1};
      vecs[15] = '{32'h00000000, 32'd0,        4'd14, 5'd16, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0, 1};
      vecs[16] = '{32'hAAAA5555, 32'h5555AAAA, 4'd15, 5'd17, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0, 1};
      vecs[17] = '{32'd3,        32'd3,        4'd1,  5'd18, 32'h00000000, 1'b1, 1'b0, 1'b0, 1};
      vecs[18] = '{32'h0000FFFF, 32'h00010001, 4'd2,  5'd31, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0, 4};

      rst       = 1'b1;
      in_valid  = 1'b0;
      in_a      = '0;
      in_b      = '0;
      in_sel    = 4'd0;
      in_rd     = 5'd0;
      out_ready = 1'b0;
      #1;
      check("reset_outputs", {out_valid, out_zero, out_neg, out_divz, busy, alu_sel, out_rd}, 32'd0);
      check("reset_res", out_res | alu_a | alu_b, 32'd0);
      tick();
      tick();
      rst = 1'b0;
      check("reset_in_ready", 32'(in_ready), 32'd1);

      for (int i = 0; i < NV; i++) run_op(vecs[i], i);

      // In-flight mul must ignore a new in_valid during EXEC.
      in_a = 32'd6; in_b = 32'd7; in_sel = 4'd2; in_rd = 5'd3;
      in_valid = 1'b1; out_ready = 1'b0;
      tick();
      in_a = 32'd1; in_b = 32'd1; in_sel = 4'd0; in_rd = 5'd9;
      bad = 1'b0;
      for (int c = 0; c < 3; c++) begin
         if (in_ready || out_valid || alu_sel != 4'd2 || alu_a != 32'd6) bad = 1'b1;
         tick();
      end
      check("mul_exec_stable", 32'(bad), 32'd0);
      tick();
      check("mul_valid_t4", 32'(out_valid), 32'd1);
      check("mul_res", out_res, 32'd42);
      check("mul_rd_not_replaced", 32'(out_rd), 32'd3);
      in_valid = 1'b0; out_ready = 1'b1;
      tick();
      check("mul_released", 32'(busy), 32'd0);

      // Backpressure, then same-edge release and accept.
      in_a = 32'd3; in_b = 32'd3; in_sel = 4'd1; in_rd = 5'd20;
      in_valid = 1'b1; out_ready = 1'b0;
      tick();
      in_valid = 1'b0;
      tick();
      bad = 1'b0;
      for (int c = 0; c < 5; c++) begin
         if (!out_valid || out_res != 32'd0 || !out_zero || in_ready || out_rd != 5'd20) bad = 1'b1;
         tick();
      end
      check("bp_hold_stable", 32'(bad), 32'd0);
      in_a = 32'd0; in_b = 32'hFFFFFFFF; in_sel = 4'd9; in_rd = 5'd7;
      in_valid = 1'b1; out_ready = 1'b1;
      #1;
      check("bp_in_ready_follows", 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0;
      check("handoff_exec", {30'd0, out_valid, busy}, 32'd1);
      tick();
      check("handoff_valid", 32'(out_valid), 32'd1);
      check("handoff_res", out_res, 32'hFFFFFFFF);
      check("handoff_neg_rd", {out_neg, out_zero, out_rd}, {2'b10, 5'd7});
      tick();
      check("handoff_released", 32'(busy), 32'd0);

      // Reset on the third cycle of a divide.
      in_a = 32'd9; in_b = 32'd3; in_sel = 4'd3; in_rd = 5'd11;
      in_valid = 1'b1; out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      #1;
      check("midrst_outputs", {out_valid, out_zero, out_neg, out_divz, busy, alu_sel, out_rd}, 32'd0);
      check("midrst_res", out_res | alu_a | alu_b, 32'd0);
      tick();
      rst = 1'b0;
      check("midrst_in_ready", 32'(in_ready), 32'd1);
      bad = 1'b0;
      for (int c = 0; c < 12; c++) begin
         if (out_valid || busy) bad = 1'b1;
         tick();
      end
      check("midrst_no_result", 32'(bad), 32'd0);
      vt = '{32'd5, 32'd7, 4'd0, 5'd1, 32'd12, 1'b0, 1'b0, 1'b0, 1};
      run_op(vt, 99);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

endmodule

// File: doc/exec_issue_stage.md
EXEC_ISSUE_STAGE -- requirements
Module: exec_issue_stage

Interface
REQ-001 Parameter: WIDTH, default 32, datapath width of operands and result.
REQ-002 Parameter: MUL_CYCLES, default 4, cycles allotted to sel=4'd2 (multiply), range 1..15.
REQ-003 Parameter: DIV_CYCLES, default 8, cycles allotted to sel=4'd3 (divide), range 1..15.
REQ-004 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-005 Port: rst  input  1  asynchronous, active-high reset.
REQ-006 Port: in_valid  input  1  upstream offers an operation.
REQ-007 Port: in_ready  output  1  stage accepts an operation this cycle.
REQ-008 Port: in_a / in_b  input  WIDTH each  operands.
REQ-009 Port: in_sel  input  4  ALU opcode: 0 add, 1 sub, 2 mul, 3 div, 4 and, 5 or, 6 xor, 7 not-A, 8 pass-A, 9 pass-B, 10 sll, 11 srl, 12 sra, 13/14 inc/dec, 15 xor (Hamming).
REQ-010 Port: in_rd  input  5  destination tag, carried through unchanged.
REQ-011 Port: alu_a / alu_b  output  WIDTH each  registered operands driven to the combinational ALU.
REQ-012 Port: alu_sel  output  4  registered opcode driven to the ALU.
REQ-013 Port: alu_res  input  WIDTH  combinational ALU result.
REQ-014 Port: out_valid  output  1  result available.
REQ-015 Port: out_ready  input  1  downstream accepts result.
REQ-016 Port: out_res  output  WIDTH  captured result.
REQ-017 Port: out_rd  output  5  tag of the captured result.
REQ-018 Port: out_zero / out_neg  output  1 each  out_res==0 / out_res[WIDTH-1].
REQ-019 Port: out_divz  output  1  captured op was divide with B==0.
REQ-020 Port: busy  output  1  state is not IDLE.

Function
REQ-021 FSM states SHALL be IDLE, EXEC, HOLD.
REQ-022 Accept SHALL occur on in_valid && in_ready; in_ready SHALL be 1 in IDLE, out_ready in HOLD, 0 in EXEC.
REQ-023 On accept, in_a/in_b/in_sel/in_rd SHALL be latched into alu_a/alu_b/alu_sel and a pending tag, and the cycle counter loaded with latency-1, then state goes to EXEC.
REQ-024 Latency SHALL be MUL_CYCLES for sel 2, DIV_CYCLES for sel 3, 1 for all other opcodes.
REQ-025 In EXEC the counter SHALL decrement each cycle; on the cycle it reads 0, alu_res SHALL be captured into out_res, tag into out_rd, flags computed from the captured value, and state goes to HOLD.
REQ-026 Accept at edge T SHALL yield out_valid high after edge T+latency.
REQ-027 alu_a, alu_b, alu_sel SHALL remain stable from accept until capture.
REQ-028 In HOLD, out_valid SHALL be 1 and out_res/out_rd/flags SHALL be stable until out_valid && out_ready.
REQ-029 Handshake in HOLD without simultaneous accept SHALL return to IDLE with out_valid 0.
REQ-030 Handshake in HOLD with simultaneous accept SHALL perform REQ-023 in the same edge (state EXEC, out_valid 0); no operation is lost or duplicated.
REQ-031 in_valid in EXEC SHALL be ignored (not accepted, no state change).
REQ-032 out_divz SHALL be 1 only when captured sel==3 and latched B==0; out_res then carries alu_res unmodified.
REQ-033 Counter SHALL be 4 bits, never wrap below 0.

Reset
REQ-034 rst high SHALL immediately force state IDLE, counter 0, out_valid 0, out_res 0, out_rd 0, out_zero 0, out_neg 0, out_divz 0, alu_a 0, alu_b 0, alu_sel 0, busy 0.
REQ-035 rst asserted during EXEC or HOLD SHALL discard the pending/held operation; in_ready SHALL be 1 on the first cycle after release.

Verification
REQ-036 add: accept A=5,B=7,sel=0 at edge T, out_ready=1 -> out_valid after T+1, out_res=12, out_zero=0, out_neg=0.
REQ-037 mul, MUL_CYCLES=4: accept A=6,B=7,sel=2 -> in_ready 0 for 3 cycles, out_res=42 after T+4; in_valid during EXEC not accepted.
REQ-038 div by zero: A=9,B=0,sel=3 -> out_valid after T+8, out_divz=1.
REQ-039 backpressure: sub A=3,B=3 with out_ready=0 for 5 cycles -> out_res=0, out_zero=1 held stable, in_ready=0; raise out_ready with in_valid pass-B B=0xFFFFFFFF -> same-edge handoff, next out_res=0xFFFFFFFF, out_neg=1.
REQ-040 reset mid-op: rst pulsed on 3rd cycle of div -> all outputs 0 immediately, no out_valid afterward, next add completes normally.
